// File: rtl/sel_parity_pipe_if.sv
// Handshake bundle for sel_parity_pipe: input word set on one side,
// registered channel words, signature and frame MISR on the other.
interface sel_parity_pipe_if #(
   parameter int W  = 4,
   parameter int CH = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [4*W-1:0]    src;
   logic [2*CH-1:0]   sel;
   logic [CH-1:0]     inv;
   logic              out_valid;
   logic              out_ready;
   logic [CH*W-1:0]   ch_data;
   logic [W-1:0]      sig;
   logic              parity;
   logic              frame_done;
   logic [W-1:0]      frame_sig;

   modport master (
      output in_valid, src, sel, inv, out_ready,
      input  in_ready, out_valid, ch_data, sig, parity,
      input  frame_done, frame_sig
   );

   modport slave (
      input  in_valid, src, sel, inv, out_ready,
      output in_ready, out_valid, ch_data, sig, parity,
      output frame_done, frame_sig
   );
endinterface

// File: rtl/sel_parity_pipe.sv
// Two-stage channel select/invert and XOR signature pipe with a
// per-frame rotating MISR over accepted results.
module sel_parity_pipe #(
   parameter int W     = 4,
   parameter int CH    = 4,
   parameter int FRAME = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   sel_parity_pipe_if.slave bus
);
   localparam int CW = $clog2(FRAME);

   logic [3:0][W-1:0]    srcw;
   logic [CH-1:0][W-1:0] mux_ch;
   logic [W-1:0]         s1_xor;
   logic [W-1:0]         misr_nxt;
   logic                 adv;
   logic                 out_hs;

   logic                 s1_valid_q, s1_valid_d;
   logic [CH-1:0][W-1:0] s1_ch_q, s1_ch_d;
   logic                 out_valid_q, out_valid_d;
   logic [CH-1:0][W-1:0] ch_q, ch_d;
   logic [W-1:0]         sig_q, sig_d;
   logic                 parity_q, parity_d;
   logic [W-1:0]         acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 fdone_q, fdone_d;
   logic [W-1:0]         fsig_q, fsig_d;

   assign srcw   = bus.src;
   assign adv    = !out_valid_q || bus.out_ready;
   assign out_hs = out_valid_q && bus.out_ready;

   assign bus.in_ready   = adv;
   assign bus.out_valid  = out_valid_q;
   assign bus.ch_data    = ch_q;
   assign bus.sig        = sig_q;
   assign bus.parity     = parity_q;
   assign bus.frame_done = fdone_q;
   assign bus.frame_sig  = fsig_q;

   // per-channel source mux with optional inversion, and stage-1 XOR fold
   always_comb begin
      mux_ch = '0;
      s1_xor = '0;
      for (int c = 0; c < CH; c++) begin
         mux_ch[c] = srcw[bus.sel[2*c +: 2]] ^ {W{bus.inv[c]}};
         s1_xor    = s1_xor ^ s1_ch_q[c];
      end
      misr_nxt = {acc_q[W-2:0], acc_q[W-1]} ^ sig_q;
   end

   // next state: flush on clr, otherwise advance pipe and fold MISR
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_ch_d     = s1_ch_q;
      out_valid_d = out_valid_q;
      ch_d        = ch_q;
      sig_d       = sig_q;
      parity_d    = parity_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      fdone_d     = 1'b0;
      fsig_d      = fsig_q;
      if (clr) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         acc_d       = '0;
         cnt_d       = '0;
      end else begin
         if (adv) begin
            s1_valid_d  = bus.in_valid;
            out_valid_d = s1_valid_q;
            if (bus.in_valid) begin
               s1_ch_d = mux_ch;
            end
            if (s1_valid_q) begin
               ch_d     = s1_ch_q;
               sig_d    = s1_xor;
               parity_d = ^s1_xor;
            end
         end
         if (out_hs) begin
            if (cnt_q == CW'(FRAME - 1)) begin
               fsig_d  = misr_nxt;
               fdone_d = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
            end else begin
               acc_d = misr_nxt;
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_ch_q     <= '0;
         out_valid_q <= 1'b0;
         ch_q        <= '0;
         sig_q       <= '0;
         parity_q    <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         fdone_q     <= 1'b0;
         fsig_q      <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_ch_q     <= s1_ch_d;
         out_valid_q <= out_valid_d;
         ch_q        <= ch_d;
         sig_q       <= sig_d;
         parity_q    <= parity_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         fdone_q     <= fdone_d;
         fsig_q      <= fsig_d;
      end
   end
endmodule
